// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC SPI sequencer.
//   state_t     : sequencer FSM states
//   START_BYTE  : first command byte clocked out to the ADC
//   MSBF_BIT    : bit of command byte1 that selects MSB-first output
//   SAMPLE_W    : width of a conversion result
//   max3()      : elaboration helper for counter sizing
//   cmd_byte()  : command byte for a given byte index
package adc_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SEND,
    WAIT_RX,
    CS_HOLD,
    CS_IDLE
  } state_t;

  localparam logic [7:0] START_BYTE = 8'h01;
  localparam int         MSBF_BIT   = 5;
  localparam int         SAMPLE_W   = 12;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // byte0 = start, byte1 = {SGL, channel, MSBF, 5'b0}, byte2 = dummy clock-out
  function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic sgl,
                                          input logic ch);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      2'd0: b = START_BYTE;
      2'd1: begin
        b[7]        = sgl;
        b[6]        = ch;
        b[MSBF_BIT] = 1'b1;
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_spi_sequencer.sv
// Sequences one 3-byte ADC conversion over an external byte-level SPI master.
// Ports:
//   i_Clk, i_Rst         : clock, synchronous active-high reset
//   i_Start, i_Channel   : conversion request pulse and channel (ignored while busy)
//   o_Busy               : high in every state except IDLE
//   o_Sample[_Chan/_DV]  : 12-bit result, its channel, one-cycle valid
//   o_TX_Byte, o_TX_DV   : byte and valid pulse toward the SPI master
//   i_TX_Ready           : SPI master can accept a byte
//   i_RX_DV, i_RX_Byte   : byte received by the SPI master
//   o_SPI_CS_n           : ADC chip select, active low
// All three timing parameters must be >= 1.
module adc_spi_sequencer
  import adc_spi_pkg::*;
#(
  parameter int unsigned CS_SETUP_CLKS = 2,
  parameter int unsigned CS_HOLD_CLKS  = 2,
  parameter int unsigned CS_IDLE_CLKS  = 4,
  parameter bit          SGL           = 1'b1
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Start,
  input  logic                i_Channel,
  output logic                o_Busy,
  output logic [SAMPLE_W-1:0] o_Sample,
  output logic                o_Sample_Chan,
  output logic                o_Sample_DV,
  output logic [7:0]          o_TX_Byte,
  output logic                o_TX_DV,
  input  logic                i_TX_Ready,
  input  logic                i_RX_DV,
  input  logic [7:0]          i_RX_Byte,
  output logic                o_SPI_CS_n
);

  localparam int CNT_MAX = max3(int'(CS_SETUP_CLKS), int'(CS_HOLD_CLKS), int'(CS_IDLE_CLKS));
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CLKS - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CLKS - 1);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(CS_IDLE_CLKS - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          chan;
  logic          hold_armed;
  logic          hold_tick;
  logic [3:0]    rx1_lo;   // only the low nibble of byte1 carries result bits
  logic [7:0]    rx2;

  // CS_HOLD counting starts once the master reports ready and keeps going after.
  assign hold_tick = hold_armed | i_TX_Ready;
  assign o_Busy    = (state != IDLE);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_TX_DV   = 1'b0;
    case (state)
      IDLE:     if (i_Start) state_nxt = CS_SETUP;
      CS_SETUP: if (cnt == SETUP_LAST) state_nxt = SEND;
      SEND: begin
        if (i_TX_Ready) begin
          o_TX_DV   = 1'b1;
          state_nxt = WAIT_RX;
        end
      end
      WAIT_RX:  if (i_RX_DV) state_nxt = (idx < 2'd2) ? SEND : CS_HOLD;
      CS_HOLD:  if (hold_tick && cnt == HOLD_LAST) state_nxt = CS_IDLE;
      CS_IDLE:  if (cnt == IDLE_LAST) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt           <= '0;
      idx           <= '0;
      chan          <= 1'b0;
      hold_armed    <= 1'b0;
      rx1_lo        <= '0;
      rx2           <= '0;
      o_TX_Byte     <= 8'h00;
      o_Sample      <= '0;
      o_Sample_Chan <= 1'b0;
      o_Sample_DV   <= 1'b0;
      o_SPI_CS_n    <= 1'b1;
    end else begin
      o_Sample_DV <= 1'b0;

      // cnt runs only in timed states and restarts on every state change
      case (state)
        CS_SETUP, CS_IDLE: cnt <= (state_nxt == state) ? cnt + CW'(1) : '0;
        CS_HOLD:           if (hold_tick) cnt <= (state_nxt == state) ? cnt + CW'(1) : '0;
        default:           cnt <= '0;
      endcase

      case (state)
        IDLE: begin
          if (i_Start) begin
            chan       <= i_Channel;
            idx        <= '0;
            hold_armed <= 1'b0;
            o_SPI_CS_n <= 1'b0;
          end
        end
        CS_SETUP: if (state_nxt == SEND) o_TX_Byte <= cmd_byte(2'd0, SGL, chan);
        WAIT_RX: begin
          if (i_RX_DV) begin
            if (idx == 2'd1) rx1_lo <= i_RX_Byte[3:0];
            if (idx == 2'd2) rx2    <= i_RX_Byte;
            if (idx < 2'd2) begin
              idx       <= idx + 2'd1;
              o_TX_Byte <= cmd_byte(idx + 2'd1, SGL, chan);
            end
          end
        end
        CS_HOLD: begin
          if (i_TX_Ready) hold_armed <= 1'b1;
          if (state_nxt == CS_IDLE) begin
            o_SPI_CS_n    <= 1'b1;
            o_Sample      <= {rx1_lo, rx2};
            o_Sample_Chan <= chan;
            o_Sample_DV   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Bench for adc_spi_sequencer: two instances (SGL=1 and SGL=0) share stimulus,
// each talking to a behavioural byte-level SPI master + ADC stand-in that
// returns 12'hA5C for channel 0 and 12'h3F1 for channel 1.
module tb_adc_spi_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic chan = 1'b0;
  logic gap_clr = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   st_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic        busy, sdv, schan, tx_dv, cs_n;
    logic [11:0] smp;
    logic [7:0]  tx_byte;
    logic        ready = 1'b1;
    logic        rxdv = 1'b0;
    logic [7:0]  rxb = 8'h00;

    adc_spi_sequencer #(.SGL(g == 0 ? 1'b1 : 1'b0)) u_dut (
      .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Channel(chan),
      .o_Busy(busy), .o_Sample(smp), .o_Sample_Chan(schan), .o_Sample_DV(sdv),
      .o_TX_Byte(tx_byte), .o_TX_DV(tx_dv), .i_TX_Ready(ready),
      .i_RX_DV(rxdv), .i_RX_Byte(rxb), .o_SPI_CS_n(cs_n)
    );

    // SPI master + ADC: 8 cycles per byte, ready and rx_dv return together.
    // Channel is decoded from bit 6 of command byte1; high nibble of reply1 is junk.
    logic        m_busy = 1'b0;
    logic        m_ch = 1'b0;
    int          m_cnt = 0;
    int          nb = 0;
    logic [11:0] ref_smp;
    assign ref_smp = m_ch ? 12'h3F1 : 12'hA5C;

    always @(posedge clk) begin
      if (rst) begin
        ready <= 1'b1; rxdv <= 1'b0; rxb <= 8'h00; m_busy <= 1'b0; nb <= 0;
      end else begin
        rxdv <= 1'b0;
        if (cs_n) nb <= 0;
        if (tx_dv) begin
          if (nb == 1) m_ch <= tx_byte[6];
          ready <= 1'b0; m_busy <= 1'b1; m_cnt <= 8;
        end else if (m_busy) begin
          if (m_cnt == 1) begin
            m_busy <= 1'b0; ready <= 1'b1; rxdv <= 1'b1; nb <= nb + 1;
            rxb <= (nb == 1) ? {4'hF, ref_smp[11:8]} : (nb == 2) ? ref_smp[7:0] : 8'h00;
          end
          m_cnt <= m_cnt - 1;
        end
      end
    end

    // monitor
    int          tx_cnt = 0, sdv_cnt = 0, dbl = 0;
    int          fall_cyc = 0, rise_cyc = 0, sdv_cyc = 0, rx_cyc = 0, min_gap = 1000;
    logic        cs_q = 1'b1;
    logic [23:0] blog = 24'h0;

    always @(negedge clk) begin
      cs_q <= cs_n;
      if (gap_clr) min_gap <= 1000;
      if (tx_dv) begin
        tx_cnt <= tx_cnt + 1;
        if (m_busy || !ready) dbl <= dbl + 1;
        blog <= {blog[15:0], tx_byte};
      end
      if (sdv) begin sdv_cnt <= sdv_cnt + 1; sdv_cyc <= cyc; end
      if (rxdv) rx_cyc <= cyc;
      if (cs_q && !cs_n) begin
        fall_cyc <= cyc;
        if (!gap_clr && rise_cyc > 0 && (cyc - rise_cyc) < min_gap) min_gap <= cyc - rise_cyc;
      end
      if (!cs_q && cs_n) rise_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((g_ch[0].busy || g_ch[1].busy) && k < 600) begin
      @(posedge clk); #1;
      k++;
    end
    chk("idle_bound", 32'(k < 600), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int target);
    int k = 0;
    while (g_ch[0].tx_cnt < target && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("tx_bound", 32'(k < 200), 32'd1);
  endtask

  task automatic pulse_start(input logic ch);
    chan = ch; start = 1'b1; st_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  int s0, s1, t0;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n",    32'(g_ch[0].cs_n),    32'd1);
    chk("rst_busy",    32'(g_ch[0].busy),    32'd0);
    chk("rst_tx_dv",   32'(g_ch[0].tx_dv),   32'd0);
    chk("rst_sdv",     32'(g_ch[0].sdv),     32'd0);
    chk("rst_tx_byte", 32'(g_ch[0].tx_byte), 32'd0);
    chk("rst_sample",  32'(g_ch[0].smp),     32'd0);
    chk("rst_chan",    32'(g_ch[0].schan),   32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_start_busy", 32'(g_ch[0].busy), 32'd0);

    // ch0: byte1 = {SGL,ch,MSBF,00000} -> A0 (SGL=1) / 20 (SGL=0)
    s0 = g_ch[0].sdv_cnt; s1 = g_ch[1].sdv_cnt;
    pulse_start(1'b0);
    wait_idle();
    chk("c0_bytes_sgl",  32'(g_ch[0].blog), 32'h01A000);
    chk("c0_bytes_diff", 32'(g_ch[1].blog), 32'h012000);
    chk("c0_sample",     32'(g_ch[0].smp),  32'hA5C);
    chk("c0_sample_d",   32'(g_ch[1].smp),  32'hA5C);
    chk("c0_chan",       32'(g_ch[0].schan), 32'd0);
    chk("c0_sdv_n",      32'(g_ch[0].sdv_cnt - s0), 32'd1);
    chk("c0_sdv_n_d",    32'(g_ch[1].sdv_cnt - s1), 32'd1);
    chk("c0_cs_fall",    32'(g_ch[0].fall_cyc - st_cyc), 32'd1);
    chk("c0_cs_rise",    32'(g_ch[0].rise_cyc - g_ch[0].rx_cyc), 32'd3);
    chk("c0_sdv_at_rise", 32'(g_ch[0].sdv_cyc - g_ch[0].rise_cyc), 32'd0);

    // ch1: byte1 E0 (SGL=1) / 60 (SGL=0), sample 3F1
    pulse_start(1'b1);
    wait_idle();
    chk("c1_bytes_sgl",  32'(g_ch[0].blog), 32'h01E000);
    chk("c1_bytes_diff", 32'(g_ch[1].blog), 32'h016000);
    chk("c1_sample",     32'(g_ch[0].smp),  32'h3F1);
    chk("c1_sample_d",   32'(g_ch[1].smp),  32'h3F1);
    chk("c1_chan",       32'(g_ch[1].schan), 32'd1);

    // start held high: back-to-back, CS_n high 4 (CS_IDLE) + 1 (IDLE) cycles
    gap_clr = 1'b1;
    @(negedge clk); #1;
    gap_clr = 1'b0;
    s0 = g_ch[0].sdv_cnt; t0 = g_ch[0].tx_cnt;
    chan = 1'b0; start = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    chk("hold_sdv_ge4",  32'((g_ch[0].sdv_cnt - s0) >= 4), 32'd1);
    chk("hold_tx_3x",    32'(g_ch[0].tx_cnt - t0), 32'(3 * (g_ch[0].sdv_cnt - s0)));
    chk("hold_cs_gap",   32'(g_ch[0].min_gap), 32'd5);
    chk("hold_dbl_dv",   32'(g_ch[0].dbl + g_ch[1].dbl), 32'd0);
    chk("hold_sample",   32'(g_ch[0].smp), 32'hA5C);

    // start pulsed during WAIT_RX of byte1 is dropped
    s0 = g_ch[0].sdv_cnt; t0 = g_ch[0].tx_cnt;
    pulse_start(1'b1);
    wait_tx(t0 + 2);
    pulse_start(1'b0);
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    chk("ign_sdv_n",  32'(g_ch[0].sdv_cnt - s0), 32'd1);
    chk("ign_tx_n",   32'(g_ch[0].tx_cnt - t0), 32'd3);
    chk("ign_busy",   32'(g_ch[0].busy), 32'd0);
    chk("ign_chan",   32'(g_ch[0].schan), 32'd1);

    // reset during WAIT_RX of byte2
    s0 = g_ch[0].sdv_cnt; t0 = g_ch[0].tx_cnt;
    pulse_start(1'b0);
    wait_tx(t0 + 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_cs_n",   32'(g_ch[0].cs_n), 32'd1);
    chk("mrst_busy",   32'(g_ch[0].busy), 32'd0);
    chk("mrst_sample", 32'(g_ch[0].smp),  32'h000);
    repeat (40) @(posedge clk);
    #1;
    chk("mrst_no_sdv", 32'(g_ch[0].sdv_cnt - s0), 32'd0);
    chk("mrst_idle",   32'(g_ch[0].busy), 32'd0);
    pulse_start(1'b1);
    wait_idle();
    chk("mrst_next_sample", 32'(g_ch[0].smp), 32'h3F1);
    chk("mrst_next_chan",   32'(g_ch[0].schan), 32'd1);
    chk("mrst_next_sdv",    32'(g_ch[0].sdv_cnt - s0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
